// File: rtl/caracol_gen.sv
// caracol_gen: emits a burst of N clean 0-then-1 pulses with a start/busy/done handshake
module caracol_gen #(
  parameter int CNT_W    = 8,
  parameter int LOW_CYC  = 2,
  parameter int HIGH_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pulses,
  output logic             a_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_sent
);
  localparam int PW = $clog2(LOW_CYC > HIGH_CYC ? LOW_CYC : HIGH_CYC) + 1;
  localparam logic [PW-1:0] LO_LOAD = PW'(LOW_CYC - 1);
  localparam logic [PW-1:0] HI_LOAD = PW'(HIGH_CYC - 1);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx, edges_nx;
  logic [PW-1:0] phase, phase_nx;
  // state, counters and edge count registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      phase      <= '0;
      edges_sent <= '0;
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      phase      <= phase_nx;
      edges_sent <= edges_nx;
    end
  end
  // next-state and counter update; edge count bumps on the LOW->HIGH step
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    phase_nx = phase;
    edges_nx = edges_sent;
    case (state)
      IDLE: if (start) begin
        edges_nx = '0;
        rem_nx   = n_pulses;
        phase_nx = LO_LOAD;
        state_nx = (n_pulses == '0) ? DONE : LOW;
      end
      LOW: if (phase != '0) phase_nx = phase - PW'(1);
      else begin
        phase_nx = HI_LOAD;
        state_nx = HIGH;
        edges_nx = edges_sent + CNT_W'(1);
      end
      HIGH: if (phase != '0) phase_nx = phase - PW'(1);
      else if (rem == CNT_W'(1)) state_nx = DONE;
      else begin
        rem_nx   = rem - CNT_W'(1);
        phase_nx = LO_LOAD;
        state_nx = LOW;
      end
      default: state_nx = IDLE;
    endcase
  end
  // outputs decode only the state register, so the line can drop to 0 only in LOW
  always_comb begin
    a_out = (state != LOW);
    busy  = (state != IDLE);
    done  = (state == DONE);
  end
endmodule

// File: tb/tb_caracol_gen.sv
// tb_caracol_gen: directed checks of burst timing, handshake and reset behaviour
module tb_caracol_gen;
  logic clk = 0, reset = 0, start = 0;
  logic [7:0] n_pulses = 0;
  logic a_out, busy, done;
  logic [7:0] edges_sent;
  int total = 0, bad = 0;

  caracol_gen dut (.clk(clk), .reset(reset), .start(start), .n_pulses(n_pulses),
                   .a_out(a_out), .busy(busy), .done(done), .edges_sent(edges_sent));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; start = 1; n_pulses = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL reset_flags cyc%0d got=%b want=100", i, {a_out, busy, done}); end
      total++; if (edges_sent !== 8'd0) begin bad++; $display("FAIL reset_edges got=%0d want=0", edges_sent); end
    end
    start = 0; reset = 1;
    tick();
    total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL reset_release got=%b want=100", {a_out, busy, done}); end
  endtask

  task automatic test_single();
    logic [4:0] ea = 5'b00111;
    n_pulses = 8'd1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if (a_out !== ea[4-i]) begin bad++; $display("FAIL single_a cyc%0d got=%b want=%b", i, a_out, ea[4-i]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy cyc%0d got=%b want=1", i, busy); end
      total++; if (done !== (i == 4)) begin bad++; $display("FAIL single_done cyc%0d got=%b want=%b", i, done, i == 4); end
      tick();
    end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b want=00", {busy, done}); end
    total++; if (edges_sent !== 8'd1) begin bad++; $display("FAIL single_edges got=%0d want=1", edges_sent); end
  endtask

  task automatic test_burst3();
    int edges = 0;
    logic prev = 1;
    n_pulses = 8'd3; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 12; i++) begin
      total++; if (a_out !== ((i % 4) >= 2)) begin bad++; $display("FAIL burst3_a cyc%0d got=%b want=%b", i, a_out, (i % 4) >= 2); end
      if (!prev && a_out) edges++;
      prev = a_out;
      tick();
    end
    total++; if ({a_out, done} !== 2'b11) begin bad++; $display("FAIL burst3_done got=%b want=11", {a_out, done}); end
    total++; if (edges !== 3) begin bad++; $display("FAIL burst3_checker got=%0d want=3", edges); end
    total++; if (edges_sent !== 8'd3) begin bad++; $display("FAIL burst3_edges got=%0d want=3", edges_sent); end
    tick();
  endtask

  task automatic test_zero();
    n_pulses = 8'd0; start = 1;
    tick();
    start = 0;
    total++; if ({a_out, busy, done} !== 3'b111) begin bad++; $display("FAIL zero_done got=%b want=111", {a_out, busy, done}); end
    total++; if (edges_sent !== 8'd0) begin bad++; $display("FAIL zero_edges got=%0d want=0", edges_sent); end
    tick();
    total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL zero_idle got=%b want=100", {a_out, busy, done}); end
  endtask

  task automatic test_back_to_back();
    int edges = 0;
    logic prev = 1;
    n_pulses = 8'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin start = 1; n_pulses = 8'd7; end
      if (i == 6) start = 0;
      total++; if (a_out !== ((i % 4) >= 2)) begin bad++; $display("FAIL ignored_a cyc%0d got=%b want=%b", i, a_out, (i % 4) >= 2); end
      if (!prev && a_out) edges++;
      prev = a_out;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ignored_done got=%b want=1", done); end
    total++; if (edges !== 2 || edges_sent !== 8'd2) begin bad++; $display("FAIL ignored_count got=%0d/%0d want=2/2", edges, edges_sent); end
    n_pulses = 8'd1; start = 1;
    tick();
    total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL b2b_idle got=%b want=100", {a_out, busy, done}); end
    tick();
    start = 0;
    total++; if ({a_out, busy, edges_sent} !== {2'b01, 8'd0}) begin bad++; $display("FAIL b2b_accept got=%b/%0d want=01/0", {a_out, busy}, edges_sent); end
    repeat (5) tick();
    total++; if ({busy, edges_sent} !== {1'b0, 8'd1}) begin bad++; $display("FAIL b2b_end got=%b/%0d want=0/1", busy, edges_sent); end
  endtask

  task automatic test_reset_mid();
    n_pulses = 8'd4; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    total++; if ({a_out, edges_sent} !== {1'b0, 8'd1}) begin bad++; $display("FAIL mid_low2 got=%b/%0d want=0/1", a_out, edges_sent); end
    reset = 0;
    tick();
    reset = 1;
    total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL mid_reset got=%b want=100", {a_out, busy, done}); end
    total++; if (edges_sent !== 8'd0) begin bad++; $display("FAIL mid_edges got=%0d want=0", edges_sent); end
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if ({a_out, busy, done} !== 3'b100) begin bad++; $display("FAIL mid_quiet cyc%0d got=%b want=100", i, {a_out, busy, done}); end
    end
  endtask

  task automatic test_max();
    int edges = 0, cyc = 0;
    logic prev = 1;
    n_pulses = 8'd255; start = 1;
    tick();
    start = 0;
    while (!done && cyc < 1100) begin
      if (!prev && a_out) edges++;
      prev = a_out;
      tick();
      cyc++;
    end
    total++; if (cyc !== 1020) begin bad++; $display("FAIL max_len got=%0d want=1020", cyc); end
    total++; if (edges !== 255 || edges_sent !== 8'd255) begin bad++; $display("FAIL max_edges got=%0d/%0d want=255/255", edges, edges_sent); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst3();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
